// File: rtl/seg7_upd_if.sv
// Update port for seg7_scan_ctrl. It carries one valid/ready transfer of a full
// display word, with NDIG packed BCD digits and digit 0 in the low nibble.
// The master offers a word and the slave (the scan controller) accepts it.
interface seg7_upd_if #(
  parameter int NDIG = 4
) ();
  logic                upd_valid;
  logic [4*NDIG-1:0]   upd_data;
  logic                upd_ready;

  modport master (output upd_valid, output upd_data, input upd_ready);
  modport slave  (input  upd_valid, input  upd_data, output upd_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// Each digit slot lasts PRESCALE cycles and is split into SHOW and GAP phases:
//  - SHOW lasts PRESCALE-BLANK_CYC cycles and drives one digit.
//  - GAP lasts BLANK_CYC cycles, with all digits dark, to stop ghosting.
// A new display word is accepted through a one-deep pending buffer. It is
// copied into the displayed shadow copy only on the frame boundary, so that a
// frame never mixes old and new digits.
// Optional build macro LEADING_ZERO_BLANK_EN: in SHOW, digit idx>=1 stays dark
// when it and every higher digit are zero. Digit 0 is always shown.
module seg7_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg7_upd_if.slave       upd_if,
  output logic [NDIG-1:0] o_dig_sel_n,
  output logic [3:0]      o_bcd,
  output logic            o_frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NDIG);

  // Terminal counts: each phase ends on the cycle where cnt equals its limit.
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - BLANK_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*NDIG-1:0]   r_shadow;
  logic [4*NDIG-1:0]   r_pending;
  logic                r_upd_ready;
  logic [NDIG-1:0]     r_dig_sel_n;
  logic [3:0]          r_bcd;
  logic                r_frame_done;

  logic                w_show_end;
  logic                w_gap_end;
  logic                w_frame_edge;
  logic                w_commit;
  logic                w_capture;
  logic [IW-1:0]       w_next_idx;
  logic [4*NDIG-1:0]   w_next_shadow;
  logic [3:0]          w_next_digit;
  logic [NDIG-1:0]     w_next_sel_n;
  logic                w_blank_digit;

  assign w_show_end   = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);
  assign w_gap_end    = (r_state == ST_GAP)  && (r_cnt == GAP_LAST);
  assign w_frame_edge = w_gap_end && (r_idx == IDX_LAST);

  // The pending buffer is full exactly when ready is low, so commit and capture
  // are mutually exclusive.
  assign w_commit  = w_frame_edge && !r_upd_ready;
  assign w_capture = upd_if.upd_valid && r_upd_ready;

  assign w_next_idx    = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
  // Digit 0 of a new frame must already show committed data, so look through
  // the commit rather than waiting a cycle for the shadow to update.
  assign w_next_shadow = w_commit ? r_pending : r_shadow;

  // Select the digit value and the one-hot-low enable for the next SHOW slot.
  always_comb begin
    // NOTE: every output of a combinational block is given a default first so
    // that no path leaves it unassigned, which would infer a latch.
    w_next_digit = 4'hF;
    w_next_sel_n = '1;
    for (int j = 0; j < NDIG; j++) begin
      if (IW'(j) == w_next_idx) begin
        w_next_digit    = w_next_shadow[4*j +: 4];
        w_next_sel_n[j] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero suppression: dark when this digit and all above it are zero.
  always_comb begin
    w_blank_digit = (w_next_idx != '0);
    for (int j = 0; j < NDIG; j++) begin
      if ((j >= int'(w_next_idx)) && (w_next_shadow[4*j +: 4] != 4'h0)) begin
        w_blank_digit = 1'b0;
      end
    end
  end
`else
  assign w_blank_digit = 1'b0;
`endif

  // Slot sequencer with registered digit enables, BCD value and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_GAP;
      r_cnt        <= '0;
      r_idx        <= IDX_LAST;
      // NOTE: the shadow is a plain register bank, not a memory, so it is reset
      // to blank and a display never shows stale data after reset.
      r_shadow     <= '1;
      r_dig_sel_n  <= '1;
      r_bcd        <= 4'hF;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every
      // right-hand side sees the values from before this edge.
      r_frame_done <= 1'b0;
      case (r_state)
        ST_SHOW: begin
          if (w_show_end) begin
            r_state     <= ST_GAP;
            r_cnt       <= '0;
            r_dig_sel_n <= '1;
            r_bcd       <= 4'hF;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (w_gap_end) begin
            r_state      <= ST_SHOW;
            r_cnt        <= '0;
            r_idx        <= w_next_idx;
            r_shadow     <= w_next_shadow;
            r_frame_done <= w_frame_edge;
            if (w_blank_digit) begin
              r_dig_sel_n <= '1;
              r_bcd       <= 4'hF;
            end else begin
              r_dig_sel_n <= w_next_sel_n;
              r_bcd       <= w_next_digit;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // One-deep update buffer: fill on handshake, drain at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_upd_ready <= 1'b1;
    end else if (w_capture) begin
      r_pending   <= upd_if.upd_data;
      r_upd_ready <= 1'b0;
    end else if (w_commit) begin
      r_upd_ready <= 1'b1;
    end
  end

  assign upd_if.upd_ready = r_upd_ready;
  assign o_dig_sel_n      = r_dig_sel_n;
  assign o_bcd            = r_bcd;
  assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, PRESCALE=8 and BLANK_CYC=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int PRESCALE  = 8;
  localparam int BLANK_CYC = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LIT_0070 = 4'b0011;
`else
  localparam logic [3:0] LIT_0070 = 4'b1111;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dig_sel_n;
  logic [3:0] bcd;
  logic       frame_done;
  int         n_vec  = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  seg7_upd_if #(.NDIG(NDIG)) upd_bus ();

  seg7_scan_ctrl #(
    .NDIG      (NDIG),
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_if       (upd_bus),
    .o_dig_sel_n  (dig_sel_n),
    .o_bcd        (bcd),
    .o_frame_done (frame_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input logic exp, input string tag);
    n_vec++;
    if (upd_bus.upd_ready !== exp) begin
      n_miss++;
      $display("FAIL %s: upd_ready=%b, expected %b", tag, upd_bus.upd_ready, exp);
    end
  endtask

  // Walk one whole frame from a boundary sample and compare every cycle.
  // On return, the bench sits on the next boundary sample.
  task automatic run_frame(input logic [15:0] digits, input logic [3:0] lit,
                           input string tag);
    logic [3:0] e_sel;
    logic [3:0] e_bcd;
    logic       e_fd;
    for (int s = 0; s < NDIG; s++) begin
      for (int c = 0; c < PRESCALE; c++) begin
        if (c < PRESCALE - BLANK_CYC && lit[s]) begin
          e_sel = ~(4'b0001 << s);
          e_bcd = digits[4*s +: 4];
        end else begin
          e_sel = 4'hF;
          e_bcd = 4'hF;
        end
        e_fd = (s == 0 && c == 0);
        n_vec++;
        if ({dig_sel_n, bcd, frame_done} !== {e_sel, e_bcd, e_fd}) begin
          n_miss++;
          $display("FAIL %s slot%0d cyc%0d: sel=%b bcd=%h fd=%b, expected sel=%b bcd=%h fd=%b",
                   tag, s, c, dig_sel_n, bcd, frame_done, e_sel, e_bcd, e_fd);
        end
        tick();
      end
    end
  endtask

  // Reset, then advance to the first frame boundary (two GAP cycles).
  task automatic apply_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    upd_bus.upd_valid = 1'b0;
    upd_bus.upd_data  = '0;
    #3;
    n_vec++;
    if ({dig_sel_n, bcd, frame_done, upd_bus.upd_ready} !== {4'hF, 4'hF, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_values: sel=%b bcd=%h fd=%b rdy=%b, expected 1111 f 0 1",
               dig_sel_n, bcd, frame_done, upd_bus.upd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_vec++;
    if ({dig_sel_n, frame_done} !== {4'hF, 1'b0}) begin
      n_miss++;
      $display("FAIL first_gap: sel=%b fd=%b, expected 1111 0", dig_sel_n, frame_done);
    end
    tick();
    run_frame(16'hFFFF, 4'b1111, "blank_frame");
  endtask

  task automatic test_update;
    fork
      run_frame(16'hFFFF, 4'b1111, "before_commit");
      begin
        repeat (5) tick();
        upd_bus.upd_valid = 1'b1;
        upd_bus.upd_data  = 16'h1234;
        tick();
        upd_bus.upd_valid = 1'b0;
        upd_bus.upd_data  = 16'h0000;
        check_ready(1'b0, "ready_low_after_capture");
        repeat (25) tick();
        check_ready(1'b0, "ready_low_until_commit");
      end
    join
    check_ready(1'b1, "ready_back_at_frame_done");
    run_frame(16'h1234, 4'b1111, "show_1234");
  endtask

  task automatic test_hold_valid;
    apply_reset();
    fork
      run_frame(16'hFFFF, 4'b1111, "hold_pre_frame");
      begin
        repeat (4) tick();
        upd_bus.upd_valid = 1'b1;
        upd_bus.upd_data  = 16'h1234;
        tick();
        upd_bus.upd_data  = 16'h5678;
        for (int k = 0; k < 26; k++) begin
          check_ready(1'b0, "hold_no_capture");
          tick();
        end
      end
    join
    check_ready(1'b1, "hold_ready_returns");
    fork
      run_frame(16'h1234, 4'b1111, "hold_1234_first");
      begin
        tick();
        check_ready(1'b0, "hold_5678_captured");
        upd_bus.upd_valid = 1'b0;
      end
    join
    run_frame(16'h5678, 4'b1111, "hold_5678_next");
  endtask

  task automatic test_reset_mid_slot;
    upd_bus.upd_valid = 1'b1;
    upd_bus.upd_data  = 16'h9999;
    tick();
    upd_bus.upd_valid = 1'b0;
    check_ready(1'b0, "mid_pending_full");
    repeat (17) tick();
    n_vec++;
    if ({dig_sel_n, bcd} !== {4'b1011, 4'h6}) begin
      n_miss++;
      $display("FAIL mid_slot2: sel=%b bcd=%h, expected 1011 6", dig_sel_n, bcd);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({dig_sel_n, bcd, frame_done, upd_bus.upd_ready} !== {4'hF, 4'hF, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL mid_reset_immediate: sel=%b bcd=%h fd=%b rdy=%b, expected 1111 f 0 1",
               dig_sel_n, bcd, frame_done, upd_bus.upd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    run_frame(16'hFFFF, 4'b1111, "pending_lost");
  endtask

  task automatic test_leading_zero;
    upd_bus.upd_valid = 1'b1;
    upd_bus.upd_data  = 16'h0070;
    fork
      run_frame(16'hFFFF, 4'b1111, "lz_pre_frame");
      begin
        tick();
        upd_bus.upd_valid = 1'b0;
      end
    join
    run_frame(16'h0070, LIT_0070, "lz_0070");
  endtask

  task automatic test_pass_through;
    upd_bus.upd_valid = 1'b1;
    upd_bus.upd_data  = 16'hC00A;
    fork
      run_frame(16'h0070, LIT_0070, "pt_pre_frame");
      begin
        tick();
        upd_bus.upd_valid = 1'b0;
        check_ready(1'b0, "pt_captured");
        repeat (3) tick();
        upd_bus.upd_valid = 1'b1;
        upd_bus.upd_data  = 16'hEEEE;
        tick();
        upd_bus.upd_valid = 1'b0;
        check_ready(1'b0, "pt_ignored_while_full");
      end
    join
    run_frame(16'hC00A, 4'b1111, "pt_c00a");
    check_ready(1'b1, "pt_no_stale_capture");
    run_frame(16'hC00A, 4'b1111, "pt_c00a_repeat");
  endtask

  initial begin
    test_reset();
    test_update();
    test_hold_valid();
    test_reset_mid_slot();
    test_leading_zero();
    test_pass_through();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
